// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory req/ack port plus the COMMAND port to the decoder.
// Optional FETCH_PERF_EN adds the perf counter outputs.
interface fetch_unit_if #(
    parameter int ADDR_W = 16
);
    // Memory handshake: a word transfers in any cycle with imem_req & imem_ack;
    // imem_addr is held stable while imem_req is high and imem_ack is low.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic              stall;
    logic              PC_load;
    logic [ADDR_W-1:0] branch_target;
    logic [15:0]       COMMAND;
    logic              cmd_valid;
    logic [ADDR_W-1:0] cmd_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]       perf_fetched;
    logic [15:0]       perf_flushes;
    logic [15:0]       perf_bubbles;
`endif

    modport master (
        output imem_req, imem_addr, COMMAND, cmd_valid, cmd_pc,
`ifdef FETCH_PERF_EN
        output perf_fetched, perf_flushes, perf_bubbles,
`endif
        input  imem_ack, imem_rdata, stall, PC_load, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, COMMAND, cmd_valid, cmd_pc,
`ifdef FETCH_PERF_EN
        input  perf_fetched, perf_flushes, perf_bubbles,
`endif
        output imem_ack, imem_rdata, stall, PC_load, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding memory reads, prefetch buffer, branch redirect.
// Optional FETCH_PERF_EN adds saturating perf counters (fetched words, flushes, bubbles).
module fetch_unit #(
    parameter int                 ADDR_W    = 16,
    parameter int                 BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [15:0]        NOP_CMD   = 16'hC0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus,
    output logic [1:0]  dbg_state_o
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DROP = 2'd2} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] drop_addr_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [15:0]       buf_cmd_q [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_q  [BUF_DEPTH];

    logic cmd_valid, req, fire, pop, redirect, push;

    assign cmd_valid = (count_q != '0);
    assign req       = (state_q == DROP) || ((state_q == FETCH) && (count_q < CW'(BUF_DEPTH)));
    assign fire      = req & bus.imem_ack;
    assign pop       = cmd_valid & ~bus.stall;
    assign redirect  = pop & bus.PC_load;
    // Words arriving in DROP or in the redirect cycle belong to the abandoned path.
    assign push      = fire && (state_q == FETCH) && !redirect;

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign bus.cmd_valid = cmd_valid;
    assign bus.COMMAND   = cmd_valid ? buf_cmd_q[rd_ptr_q] : NOP_CMD;
    assign bus.cmd_pc    = cmd_valid ? buf_pc_q[rd_ptr_q] : last_pc_q;
    assign dbg_state_o   = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            last_pc_q   <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: state_q <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        fetch_pc_q <= bus.branch_target;
                        // Request in flight without ack: keep it alive in DROP so addr stays stable.
                        if (req && !bus.imem_ack) begin
                            state_q     <= DROP;
                            drop_addr_q <= fetch_pc_q;
                        end
                    end else if (fire) begin
                        fetch_pc_q <= fetch_pc_q + 1'b1;
                    end
                end
                DROP: if (bus.imem_ack) state_q <= FETCH;
                default: state_q <= IDLE;
            endcase

            if (pop) last_pc_q <= buf_pc_q[rd_ptr_q];

            if (redirect) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_cmd_q[wr_ptr_q] <= bus.imem_rdata;
            buf_pc_q[wr_ptr_q]  <= fetch_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_flushes_q, perf_bubbles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_flushes_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (fire && perf_fetched_q != 16'hFFFF) perf_fetched_q <= perf_fetched_q + 1'b1;
            if (redirect && perf_flushes_q != 16'hFFFF) perf_flushes_q <= perf_flushes_q + 1'b1;
            if (!cmd_valid && !bus.stall && perf_bubbles_q != 16'hFFFF)
                perf_bubbles_q <= perf_bubbles_q + 1'b1;
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_flushes = perf_flushes_q;
    assign bus.perf_bubbles = perf_bubbles_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall/full, redirects with and without DROP,
// PC wrap, and asynchronous reset in the middle of DROP.
module tb_fetch_unit;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    fetch_unit_if #(.ADDR_W(16)) bus ();

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Memory contents: a fixed scramble of the address, so every word is distinct.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'h3C};
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst_n             = 1'b1;
        bus.imem_ack      = 1'b1;
        bus.stall         = 1'b0;
        bus.PC_load       = 1'b0;
        bus.branch_target = 16'h0000;

        // asynchronous reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("rst_req",   16'(bus.imem_req),  16'h0000);
        chk("rst_addr",  bus.imem_addr,      16'h0000);
        chk("rst_valid", 16'(bus.cmd_valid), 16'h0000);
        chk("rst_cmd",   bus.COMMAND,        16'hC0F0);
        chk("rst_pc",    bus.cmd_pc,         16'h0000);
        chk("rst_state", 16'(dbg_state),     16'h0000);

        tick();
        chk("rst_hold_req", 16'(bus.imem_req), 16'h0000);
        rst_n = 1'b1;

        // first request one cycle after release
        tick();
        chk("p1_state", 16'(dbg_state),     16'h0001);
        chk("p1_req",   16'(bus.imem_req),  16'h0001);
        chk("p1_addr",  bus.imem_addr,      16'h0000);
        chk("p1_valid", 16'(bus.cmd_valid), 16'h0000);

        tick();
        chk("p2_addr",  bus.imem_addr,      16'h0001);
        chk("p2_valid", 16'(bus.cmd_valid), 16'h0001);
        chk("p2_cmd",   bus.COMMAND,        mem_word(16'h0000));
        chk("p2_pc",    bus.cmd_pc,         16'h0000);

        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("stream_addr", bus.imem_addr, 16'(k - 1));
            chk("stream_cmd",  bus.COMMAND,   mem_word(16'(k - 2)));
            chk("stream_pc",   bus.cmd_pc,    16'(k - 2));
        end

        // stall for 5 cycles: buffer fills to 2, request drops, head frozen at 3
        bus.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_req",   16'(bus.imem_req),  16'h0000);
            chk("stall_valid", 16'(bus.cmd_valid), 16'h0001);
            chk("stall_cmd",   bus.COMMAND,        mem_word(16'h0003));
            chk("stall_pc",    bus.cmd_pc,         16'h0003);
            chk("stall_addr",  bus.imem_addr,      16'h0005);
        end
        bus.stall = 1'b0;

        tick();
        chk("unstall_cmd",  bus.COMMAND,       mem_word(16'h0004));
        chk("unstall_pc",   bus.cmd_pc,        16'h0004);
        chk("unstall_req",  16'(bus.imem_req), 16'h0001);
        chk("unstall_addr", bus.imem_addr,     16'h0005);

        // redirect to 0x40 while 0x0005 is acked in the same cycle
        bus.PC_load       = 1'b1;
        bus.branch_target = 16'h0040;
        tick();
        bus.PC_load = 1'b0;
        chk("br1_valid", 16'(bus.cmd_valid), 16'h0000);
        chk("br1_cmd",   bus.COMMAND,        16'hC0F0);
        chk("br1_pc",    bus.cmd_pc,         16'h0004);
        chk("br1_addr",  bus.imem_addr,      16'h0040);
        chk("br1_req",   16'(bus.imem_req),  16'h0001);
        tick();
        chk("br1_tgt_cmd",  bus.COMMAND,   mem_word(16'h0040));
        chk("br1_tgt_pc",   bus.cmd_pc,    16'h0040);
        chk("br1_tgt_addr", bus.imem_addr, 16'h0041);

        // delayed ack; PC_load arrives while 0x41 is pending -> DROP
        bus.imem_ack = 1'b0;
        bus.stall    = 1'b1;
        tick();
        chk("wait_addr", bus.imem_addr,     16'h0041);
        chk("wait_req",  16'(bus.imem_req), 16'h0001);
        chk("wait_cmd",  bus.COMMAND,       mem_word(16'h0040));
        bus.stall         = 1'b0;
        bus.PC_load       = 1'b1;
        bus.branch_target = 16'h0080;
        tick();
        bus.PC_load = 1'b0;
        chk("drop_state", 16'(dbg_state),     16'h0002);
        chk("drop_req",   16'(bus.imem_req),  16'h0001);
        chk("drop_addr",  bus.imem_addr,      16'h0041);
        chk("drop_valid", 16'(bus.cmd_valid), 16'h0000);
        tick();
        chk("drop2_state", 16'(dbg_state),     16'h0002);
        chk("drop2_addr",  bus.imem_addr,      16'h0041);
        chk("drop2_valid", 16'(bus.cmd_valid), 16'h0000);
        bus.imem_ack = 1'b1;
        tick();
        chk("undrop_state", 16'(dbg_state),     16'h0001);
        chk("undrop_addr",  bus.imem_addr,      16'h0080);
        chk("undrop_valid", 16'(bus.cmd_valid), 16'h0000);
        chk("undrop_cmd",   bus.COMMAND,        16'hC0F0);
        tick();
        chk("tgt80_cmd",  bus.COMMAND,   mem_word(16'h0080));
        chk("tgt80_pc",   bus.cmd_pc,    16'h0080);
        chk("tgt80_addr", bus.imem_addr, 16'h0081);

        // PC wrap from 0xFFFF to 0x0000
        bus.PC_load       = 1'b1;
        bus.branch_target = 16'hFFFF;
        tick();
        bus.PC_load = 1'b0;
        chk("wrap_addr0",  bus.imem_addr,      16'hFFFF);
        chk("wrap_valid0", 16'(bus.cmd_valid), 16'h0000);
        tick();
        chk("wrap_addr1", bus.imem_addr, 16'h0000);
        chk("wrap_cmd1",  bus.COMMAND,   mem_word(16'hFFFF));
        chk("wrap_pc1",   bus.cmd_pc,    16'hFFFF);
        tick();
        chk("wrap_addr2", bus.imem_addr, 16'h0001);
        chk("wrap_cmd2",  bus.COMMAND,   mem_word(16'h0000));
        chk("wrap_pc2",   bus.cmd_pc,    16'h0000);

        // enter DROP again, then assert reset asynchronously mid-DROP
        bus.imem_ack      = 1'b0;
        bus.PC_load       = 1'b1;
        bus.branch_target = 16'h0020;
        tick();
        bus.PC_load = 1'b0;
        chk("drop3_state", 16'(dbg_state),    16'h0002);
        chk("drop3_req",   16'(bus.imem_req), 16'h0001);
        chk("drop3_addr",  bus.imem_addr,     16'h0001);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   16'(bus.imem_req),  16'h0000);
        chk("mid_rst_valid", 16'(bus.cmd_valid), 16'h0000);
        chk("mid_rst_addr",  bus.imem_addr,      16'h0000);
        chk("mid_rst_state", 16'(dbg_state),     16'h0000);
        chk("mid_rst_cmd",   bus.COMMAND,        16'hC0F0);
        tick();
        bus.imem_ack = 1'b1;
        rst_n        = 1'b1;
        tick();
        chk("restart_state", 16'(dbg_state),     16'h0001);
        chk("restart_req",   16'(bus.imem_req),  16'h0001);
        chk("restart_addr",  bus.imem_addr,      16'h0000);
        chk("restart_valid", 16'(bus.cmd_valid), 16'h0000);
        tick();
        chk("restart_cmd",  bus.COMMAND,   mem_word(16'h0000));
        chk("restart_pc",   bus.cmd_pc,    16'h0000);
        chk("restart_addr2", bus.imem_addr, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
